fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of synchronous_fifo among NUM_REQ producers.
//  Sits between producer agents and the FIFO's data_in/wr_en; honours full as backpressure.
//  Tracks FIFO occupancy from accepted writes and reads, and reports the granted requester.
// PARAMETERS
//  NUM_REQ     4   number of producers (>=2)
//  DATA_WIDTH  8   FIFO word width
//  DEPTH       16  FIFO depth (power of 2); sizes occupancy counter ($clog2(DEPTH)+1 bits)
//  BURST_LEN   4   max consecutive writes per grant (used only with FIFO_ARB_BURST_EN)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst_n        in   1                  asynchronous reset, active low
//  req_valid    in   NUM_REQ            producer i has a word
//  req_data     in   NUM_REQ*DATA_WIDTH producer i word = slice [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready    out  NUM_REQ            one-hot; word of producer i accepted this cycle
//  fifo_full    in   1                  synchronous_fifo full
//  fifo_empty   in   1                  synchronous_fifo empty
//  fifo_rd_en   in   1                  consumer read strobe (observed only)
//  fifo_wr_en   out  1                  write strobe to synchronous_fifo
//  fifo_data_in out  DATA_WIDTH         write data to synchronous_fifo
//  grant_id     out  $clog2(NUM_REQ)    index of producer written this cycle (hold last otherwise)
//  occupancy    out  $clog2(DEPTH)+1    words currently stored
// BEHAVIOUR
//  Reset (async, rst_n=0): rr_ptr=0, grant_id=0, occupancy=0, state=IDLE, burst_cnt=0;
//   req_ready=0, fifo_wr_en=0 combinationally while reset is asserted.
//  Grant (combinational): winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//  fifo_wr_en = |req_valid & !fifo_full; req_ready = onehot(winner) & {NUM_REQ{fifo_wr_en}}.
//  fifo_data_in = req_data slice of winner; zero latency. Accept = req_valid[i] & req_ready[i].
//  Producer must hold req_valid/data until accepted. Dropping req_valid before accept is allowed.
//  On accept: rr_ptr <= winner+1 mod NUM_REQ (wrap NUM_REQ-1 -> 0), grant_id <= winner.
//  No accept (full or no request): rr_ptr and grant_id hold.
//  Occupancy: wr = fifo_wr_en; rd = fifo_rd_en & !fifo_empty.
//   wr&!rd -> +1; rd&!wr -> -1; both or neither -> hold. Saturate at 0 and DEPTH (never wraps).
//  Simultaneous read while full: no write that cycle (full is sampled as-is); write on the next cycle.
//  Reset mid-operation: all state cleared; the in-flight handshake is lost; producers re-present.
// CONFIGURATION
//  FIFO_ARB_BURST_EN defined: 2-state FSM IDLE/LOCKED.
//   IDLE: on accept from winner w -> LOCKED, lock_id=w, burst_cnt=1 (BURST_LEN=1: stay IDLE).
//   LOCKED: winner forced to lock_id while req_valid[lock_id]=1. Each accept -> burst_cnt++.
//   LOCKED exits to IDLE when burst_cnt reaches BURST_LEN or req_valid[lock_id] drops.
//   On exit, rr_ptr = lock_id+1. fifo_full stalls inside LOCKED without consuming burst count.
//  Not defined: no FSM; rr_ptr advances after every accept (pure round robin); BURST_LEN ignored.
// STRUCTURE
//  Package fifo_arb_pkg: arb_state_e {IDLE, LOCKED}; function rr_pick(valid, ptr) returning the index;
//   localparams IDX_W=$clog2(NUM_REQ), OCC_W=$clog2(DEPTH)+1.
//  One sub-module: fifo_occ_counter (up/down saturating counter, async active-low reset).
//  Top level: rr_pick mux, pointer/grant registers, optional FSM, and fifo_occ_counter instance.
// TESTING
//  1 Reset then all 4 req_valid=1, not full: accept order 0,1,2,3,0; grant_id follows; occupancy 1..5.
//  2 Only req 2 valid while rr_ptr=3: selection wraps, grant 2 immediately; rr_ptr becomes 3.
//  3 fifo_full=1 with requests pending: fifo_wr_en=0, req_ready=0, rr_ptr held; full drops -> same winner writes.
//  4 Occupancy 16 (full) with fifo_rd_en=1: occupancy 15, no write that cycle; next cycle write -> 16.
//  5 rst_n pulsed low mid-stream: outputs 0 in the same cycle, occupancy 0, first grant is req 0.
//  6 FIFO_ARB_BURST_EN, BURST_LEN=4, reqs 0,1 valid: grants 0,0,0,0,1,1,1,1; 0 drops at 2 -> switch to 1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e : burst-lock FSM states (used only with FIFO_ARB_BURST_EN)
//   rr_pick     : round-robin search returning the first valid index at or after ptr
//   IDX_W/OCC_W : grant-index and occupancy widths for the default configuration
package fifo_arb_pkg;

  localparam int unsigned NUM_REQ_DFLT = 4;
  localparam int unsigned DEPTH_DFLT   = 16;
  localparam int unsigned IDX_W        = $clog2(NUM_REQ_DFLT);
  localparam int unsigned OCC_W        = $clog2(DEPTH_DFLT) + 1;
  // Widest request vector rr_pick can search.
  localparam int unsigned MAX_REQ      = 32;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  // Search ptr, ptr+1, ... (mod num) and return the first index with valid set.
  // Returns ptr when nothing is valid; callers gate the result with |valid.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned         ptr,
                                          input int unsigned         num);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= num) idx = idx - num;
      if (i < num && !found && valid[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/fifo_occ_counter.sv
// Up/down occupancy counter saturating at 0 and DEPTH.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : a word was written this cycle
//   dec        : a word was read this cycle
//   count      : words currently stored
module fifo_occ_counter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q != WIDTH'(DEPTH)) begin
      count_d = count_q + WIDTH'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional burst locking is enabled by defining FIFO_ARB_BURST_EN.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-producer word available
//   req_data     : producer i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    : one-hot accept, zero latency
//   fifo_full    : FIFO backpressure
//   fifo_empty   : FIFO empty (masks reads for occupancy tracking)
//   fifo_rd_en   : consumer read strobe, observed only
//   fifo_wr_en   : FIFO write strobe
//   fifo_data_in : FIFO write data (winner's word)
//   grant_id     : producer written most recently
//   occupancy    : words stored, tracked from writes and reads
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic                          fifo_rd_en,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [$clog2(DEPTH):0]        occupancy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned OccW = $clog2(DEPTH) + 1;

  logic [IdxW-1:0] rr_ptr_q, grant_id_q, winner, winner_inc;
  logic            wr_en;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CntW = $clog2(BURST_LEN + 1);

  arb_state_e      state_q;
  logic [IdxW-1:0] lock_id_q;
  logic [CntW-1:0] burst_cnt_q;
  logic            locked_active;

  // Lock only binds while its owner keeps requesting; a drop behaves as IDLE.
  assign locked_active = (state_q == LOCKED) && req_valid[lock_id_q];
`else
  if (BURST_LEN == 0) begin : g_no_burst
    // Burst length has no effect without FIFO_ARB_BURST_EN.
  end
`endif

  always_comb begin
    winner = IdxW'(rr_pick(MAX_REQ'(req_valid), 32'(rr_ptr_q), NUM_REQ));
`ifdef FIFO_ARB_BURST_EN
    if (locked_active) winner = lock_id_q;
`endif
  end

  // Gated by rst_n so no handshake appears while reset is held.
  assign wr_en      = (|req_valid) & ~fifo_full & rst_n;
  assign fifo_wr_en = wr_en;
  assign req_ready  = wr_en ? (NUM_REQ'(1) << winner) : '0;
  assign winner_inc = (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + IdxW'(1);

  always_comb begin
    fifo_data_in = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IdxW'(i)) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else if (wr_en) begin
      rr_ptr_q   <= winner_inc;
      grant_id_q <= winner;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_id_q   <= '0;
      burst_cnt_q <= '0;
    end else if (locked_active) begin
      // Full stalls here without consuming burst count.
      if (wr_en) begin
        if (32'(burst_cnt_q) + 1 >= BURST_LEN) begin
          state_q     <= IDLE;
          burst_cnt_q <= '0;
        end else begin
          burst_cnt_q <= burst_cnt_q + CntW'(1);
        end
      end
    end else if (wr_en && BURST_LEN > 1) begin
      state_q     <= LOCKED;
      lock_id_q   <= winner;
      burst_cnt_q <= CntW'(1);
    end else begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end
  end
`endif

  assign grant_id = grant_id_q;

  fifo_occ_counter #(
    .DEPTH (DEPTH),
    .WIDTH (OccW)
  ) u_occ (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_en),
    .dec   (fifo_rd_en & ~fifo_empty),
    .count (occupancy)
  );

endmodule
